// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NUM_RD combinational read ports,
// optional hardwired-zero entry 0, optional write-to-read bypass, and a post-reset clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       regwrite,
    input  logic [ADDR_W-1:0]          write_address,
    input  logic [DATA_W-1:0]          reg_wr,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   read_address,
    output logic [NUM_RD*DATA_W-1:0]   reg_re,
    output logic                       init_busy,
    output logic                       write_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clear_idx_q, clear_idx_d;
    logic                write_drop_q, write_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic wr_to_zero;
    logic wr_active;
    logic wr_en;

    assign wr_to_zero = (ZERO_REG != 0) && (write_address == '0);
    assign wr_active  = regwrite && (state_q == ST_READY);
    assign wr_en      = wr_active && !wr_to_zero;

    always_comb begin
        state_d      = state_q;
        clear_idx_d  = clear_idx_q;
        write_drop_d = regwrite && !wr_en;
        if (state_q == ST_CLEAR) begin
            // Index wraps back to zero on the last step, ready for the next reset.
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clear_idx_q  <= '0;
            write_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_idx_q  <= clear_idx_d;
            write_drop_q <= write_drop_d;
        end
    end

    // Storage carries no reset; it only becomes defined once the sweep finishes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clear_idx_q] <= '0;
            end else if (wr_en) begin
                mem_q[write_address] <= reg_wr;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit_zero;
        logic              hit_byp;
        logic [DATA_W-1:0] rd_data;

        assign ra       = read_address[i*ADDR_W +: ADDR_W];
        assign hit_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit_byp  = (BYPASS != 0) && wr_active && (ra == write_address);

        always_comb begin
            rd_data = '0;
            if (rd_en[i] && (state_q == ST_READY) && !hit_zero) begin
                rd_data = hit_byp ? reg_wr : mem_q[ra];
            end
        end

        assign reg_re[i*DATA_W +: DATA_W] = rd_data;
    end

    assign init_busy  = (state_q == ST_CLEAR);
    assign write_drop = write_drop_q;

endmodule
